// File: rtl/bsg_two_skid_pkg.sv
// Shared types and constants for the two-entry skid buffer.
package bsg_two_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  localparam int unsigned stall_cnt_width_gp = 16;

endpackage

// File: rtl/bsg_dff_en_nreset.sv
// Enabled storage slot with synchronous active-low reset to zero.
// Widths 3..90 with harden_p=1 are built as per-bit reset-flop slices
// (hardened cell footprint); all other cases use a behavioural vector flop.
module bsg_dff_en_nreset
  import bsg_two_skid_pkg::*;
#(
  parameter int width_p  = -1,
  parameter bit harden_p = 1'b1
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;
  logic [width_p-1:0] data_d;

  // Load new payload only when enabled
  always_comb begin
    data_d = data_q;
    if (en_i) data_d = data_i;
  end

  if (harden_p && (width_p >= 3) && (width_p <= 90)) begin : g_hard
    for (genvar i = 0; i < width_p; i++) begin : g_slice
      // One reset-flop bit-slice per payload bit
      always_ff @(posedge clk_i) begin
        if (!nreset_i) data_q[i] <= 1'b0;
        else           data_q[i] <= data_d[i];
      end
    end
  end else begin : g_behav
    // Behavioural vector flop
    always_ff @(posedge clk_i) begin
      if (!nreset_i) data_q <= '0;
      else           data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_two_skid_nreset.sv
// Two-entry ready/valid skid buffer with registered valid/data outputs.
// Optional stall counter enabled by defining BSG_TWO_SKID_STALL_CNT_EN.
module bsg_two_skid_nreset
  import bsg_two_skid_pkg::*;
#(
  parameter int width_p  = -1,
  parameter bit harden_p = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic                          v_i,
  input  logic [width_p-1:0]            data_i,
  output logic                          ready_o,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  input  logic                          yumi_i,
  output logic [stall_cnt_width_gp-1:0] stall_cnt_o
);

  skid_state_e state_q, state_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic        enq, deq;
  logic [width_p-1:0] slot0, slot1;

  assign ready_o = (state_q != FULL);
  assign v_o     = (state_q != EMPTY);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = head_q ? slot1 : slot0;

  bsg_dff_en_nreset #(.width_p(width_p), .harden_p(harden_p)) slot0_inst (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .en_i     (enq & ~tail_q),
    .data_i   (data_i),
    .data_o   (slot0)
  );

  bsg_dff_en_nreset #(.width_p(width_p), .harden_p(harden_p)) slot1_inst (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .en_i     (enq & tail_q),
    .data_i   (data_i),
    .data_o   (slot1)
  );

  // Occupancy transitions and pointer advance
  always_comb begin
    state_d = state_q;
    head_d  = head_q ^ deq;
    tail_d  = tail_q ^ enq;
    unique case (state_q)
      EMPTY:   if (enq) state_d = ONE;
      ONE: begin
        if (enq & ~deq)      state_d = FULL;
        else if (deq & ~enq) state_d = EMPTY;
      end
      FULL:    if (deq) state_d = ONE;
      default: begin
        state_d = EMPTY;
        head_d  = 1'b0;
        tail_d  = 1'b0;
      end
    endcase
  end

  // State and pointer registers
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef BSG_TWO_SKID_STALL_CNT_EN
  logic [stall_cnt_width_gp-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the head waits for the consumer
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (v_o & ~yumi_i & (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Stall counter register
  always_ff @(posedge clk_i) begin
    if (!nreset_i) stall_cnt_q <= '0;
    else           stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  // Consumer must not take from an empty buffer
  a_no_yumi_when_empty: assert property (
    @(posedge clk_i) disable iff (!nreset_i) !(yumi_i && !v_o)
  );

endmodule

// File: tb/tb_bsg_two_skid_nreset.sv
// Directed self-checking bench for bsg_two_skid_nreset (width_p=8).
module tb_bsg_two_skid_nreset;

  logic        clk_i = 1'b0;
  logic        nreset_i;
  logic        v_i;
  logic [7:0]  data_i;
  logic        ready_o;
  logic        v_o;
  logic [7:0]  data_o;
  logic        yumi_i;
  logic [15:0] stall_cnt_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  bsg_two_skid_nreset #(.width_p(8), .harden_p(1'b1)) dut (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    nreset_i = 1'b0; v_i = 1'b1; data_i = 8'hAA; yumi_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({v_o, data_o, ready_o} !== {1'b0, 8'h00, 1'b1})
        $display("FAIL reset_hold cyc%0d: v=%b data=%h ready=%b, want v=0 data=00 ready=1",
                 i, v_o, data_o, ready_o);
      else n_pass++;
    end
    nreset_i = 1'b1; data_i = 8'h3C;
    tick();
    n_total++;
    if ({v_o, data_o, ready_o} !== {1'b1, 8'h3C, 1'b1})
      $display("FAIL reset_first_enq: v=%b data=%h ready=%b, want v=1 data=3c ready=1",
               v_o, data_o, ready_o);
    else n_pass++;
    v_i = 1'b0; yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    n_total++;
    if (v_o !== 1'b0) $display("FAIL reset_drain: v=%b, want 0", v_o);
    else n_pass++;
  endtask

  task automatic test_streaming();
    int unsigned errs = 0;
    v_i = 1'b1; data_i = 8'd1; yumi_i = 1'b0;
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (v_o !== 1'b1 || data_o !== 8'(k) || ready_o !== 1'b1) begin
        errs++;
        $display("FAIL stream_item%0d: v=%b data=%0d ready=%b, want v=1 data=%0d ready=1",
                 k, v_o, data_o, ready_o, k);
      end
      yumi_i = 1'b1;
      v_i    = (k < 20);
      data_i = 8'(k + 1);
      tick();
    end
    v_i = 1'b0; yumi_i = 1'b0;
    n_total++;
    if (errs == 0) n_pass++;
    n_total++;
    if (v_o !== 1'b0) $display("FAIL stream_empty: v=%b, want 0", v_o);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    v_i = 1'b1; data_i = 8'h11; yumi_i = 1'b0;
    tick();
    data_i = 8'h22;
    tick();
    n_total++;
    if ({ready_o, v_o, data_o} !== {1'b0, 1'b1, 8'h11})
      $display("FAIL bp_full: ready=%b v=%b data=%h, want ready=0 v=1 data=11",
               ready_o, v_o, data_o);
    else n_pass++;
    data_i = 8'h33;
    tick();
    n_total++;
    if ({ready_o, data_o} !== {1'b0, 8'h11})
      $display("FAIL bp_hold: ready=%b data=%h, want ready=0 data=11", ready_o, data_o);
    else n_pass++;
    yumi_i = 1'b1;
    tick();
    n_total++;
    if ({ready_o, v_o, data_o} !== {1'b1, 1'b1, 8'h22})
      $display("FAIL bp_second: ready=%b v=%b data=%h, want ready=1 v=1 data=22",
               ready_o, v_o, data_o);
    else n_pass++;
    tick();
    n_total++;
    if ({v_o, data_o} !== {1'b1, 8'h33})
      $display("FAIL bp_third: v=%b data=%h, want v=1 data=33", v_o, data_o);
    else n_pass++;
    v_i = 1'b0;
    tick();
    yumi_i = 1'b0;
    n_total++;
    if (v_o !== 1'b0) $display("FAIL bp_drain: v=%b, want 0", v_o);
    else n_pass++;
  endtask

  task automatic test_simul_enq_deq();
    v_i = 1'b1; data_i = 8'h5A; yumi_i = 1'b0;
    tick();
    data_i = 8'hA5; yumi_i = 1'b1;
    tick();
    n_total++;
    if ({v_o, ready_o, data_o} !== {1'b1, 1'b1, 8'hA5})
      $display("FAIL simul_one: v=%b ready=%b data=%h, want v=1 ready=1 data=a5",
               v_o, ready_o, data_o);
    else n_pass++;
    v_i = 1'b0;
    tick();
    yumi_i = 1'b0;
    n_total++;
    if (v_o !== 1'b0) $display("FAIL simul_drain: v=%b, want 0", v_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    v_i = 1'b1; data_i = 8'h77; yumi_i = 1'b0;
    tick();
    data_i = 8'h88;
    tick();
    n_total++;
    if (ready_o !== 1'b0) $display("FAIL mid_full: ready=%b, want 0", ready_o);
    else n_pass++;
    v_i = 1'b0; nreset_i = 1'b0;
    tick();
    nreset_i = 1'b1;
    n_total++;
    if ({v_o, ready_o, data_o} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL mid_reset: v=%b ready=%b data=%h, want v=0 ready=1 data=00",
               v_o, ready_o, data_o);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (v_o !== 1'b0) $display("FAIL mid_idle: v=%b, want 0", v_o);
    else n_pass++;
    v_i = 1'b1; data_i = 8'h99;
    tick();
    n_total++;
    if ({v_o, data_o} !== {1'b1, 8'h99})
      $display("FAIL mid_new: v=%b data=%h, want v=1 data=99", v_o, data_o);
    else n_pass++;
    v_i = 1'b0; yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    n_total++;
    if (v_o !== 1'b0) $display("FAIL mid_drain: v=%b, want 0 (stale entry)", v_o);
    else n_pass++;
  endtask

  task automatic test_stall_cnt();
    nreset_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    tick();
    nreset_i = 1'b1;
    n_total++;
    if (stall_cnt_o !== 16'h0000)
      $display("FAIL stall_reset: cnt=%h, want 0000", stall_cnt_o);
    else n_pass++;
    v_i = 1'b1; data_i = 8'h42;
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
`ifdef BSG_TWO_SKID_STALL_CNT_EN
    n_total++;
    if (stall_cnt_o !== 16'd5) $display("FAIL stall_five: cnt=%0d, want 5", stall_cnt_o);
    else n_pass++;
    for (int i = 0; i < 70000; i++) tick();
    n_total++;
    if (stall_cnt_o !== 16'hFFFF)
      $display("FAIL stall_sat: cnt=%h, want ffff", stall_cnt_o);
    else n_pass++;
`else
    n_total++;
    if (stall_cnt_o !== 16'h0000)
      $display("FAIL stall_off: cnt=%h, want 0000", stall_cnt_o);
    else n_pass++;
    for (int i = 0; i < 100; i++) tick();
    n_total++;
    if (stall_cnt_o !== 16'h0000)
      $display("FAIL stall_off_long: cnt=%h, want 0000", stall_cnt_o);
    else n_pass++;
`endif
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    n_total++;
    if (v_o !== 1'b0) $display("FAIL stall_drain: v=%b, want 0", v_o);
    else n_pass++;
  endtask

  initial begin
    nreset_i = 1'b0; v_i = 1'b0; data_i = '0; yumi_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_simul_enq_deq();
    test_reset_mid_op();
    test_stall_cnt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bsg_two_skid_nreset.md
Name: bsg_two_skid_nreset

Overview:
Two-entry ready/valid skid buffer that sits directly upstream of the hardened reset-flop stage. It decouples a producer from a consumer whose ready may drop at any cycle, and presents a registered valid/data pair to the downstream flop bank. Both storage slots are built from hardened TSMC-40 reset-flop bit-slices when a matching width exists. Otherwise they are built from behavioural flops.

Parameters:
width_p, -1 (must be set, >=1), payload width in bits
harden_p, 1, 1 = use hardened nreset flop cells for the storage slots when available; 0 = behavioural

Ports:
clk_i  input  1  sole clock, rising edge
nreset_i  input  1  synchronous active-low reset
v_i  input  1  producer data valid
data_i  input  width_p  producer payload
ready_o  output  1  buffer can accept this cycle
v_o  output  1  head entry valid
data_o  output  width_p  head entry payload
yumi_i  input  1  consumer takes head this cycle (legal only when v_o=1)
stall_cnt_o  output  16  cycles with v_o=1 and yumi_i=0 (optional feature)

Behaviour:
- One clock (clk_i); reset is synchronous and active-low (nreset_i), sampled on the rising edge of clk_i. There is no asynchronous path.
- State: EMPTY (0 entries), ONE (1 entry), FULL (2 entries). Two slots are addressed by 1-bit head and tail pointers.
- Reset (nreset_i=0 at an edge): state=EMPTY, head=tail=0, both slots=0, stall count=0.
  - After that edge: v_o=0, data_o=0, ready_o=1.
  - While nreset_i=0, v_i and yumi_i are ignored.
- ready_o = (state != FULL); combinational from the state register only, with no path from v_i or yumi_i.
- v_o = (state != EMPTY); data_o = slot[head]. Both are driven purely from registers.
- enq = v_i & ready_o; deq = yumi_i & v_o.
- Latency: data accepted at edge N is visible on data_o after edge N (one cycle) when the buffer was EMPTY.
- Transitions:
  - EMPTY: enq -> ONE; otherwise stay.
  - ONE: enq & !deq -> FULL; deq & !enq -> EMPTY; enq & deq -> ONE (slot written, head advances).
  - FULL: deq -> ONE; enq is impossible because ready_o=0.
- Writes go to slot[tail], after which tail toggles. deq toggles head. Pointers wrap modulo 2.
- Ordering is strict FIFO, with no drop and no duplicate.
- yumi_i while v_o=0 is illegal. The design ignores it (no state change). It is flagged by an assertion in simulation.
- v_i may be held high while ready_o=0. data_i is sampled only on enq.
- Reset mid-operation discards both entries. The next cycle shows v_o=0.

Optional Feature:
- Macro BSG_TWO_SKID_STALL_CNT_EN.
- Defined: a 16-bit saturating counter increments on every cycle with v_o=1 & yumi_i=0. It holds at 16'hFFFF and is cleared by reset. stall_cnt_o drives the counter value.
- Undefined: no counter logic is present and stall_cnt_o is tied to 16'h0000.

Decomposition:
- Package bsg_two_skid_pkg:
  - 2-bit enum skid_state_e {EMPTY=2'b00, ONE=2'b01, FULL=2'b10}
  - localparam stall_cnt_width_gp=16
- Sub-module bsg_dff_en_nreset: a width_p-wide enabled storage slot with synchronous active-low reset to 0.
  - It is instantiated twice.
  - It selects the hardened nreset bit-slice cell for width_p 3..90 when harden_p=1, and behavioural flops otherwise.
- Pointer and state logic stay in the top level.

Test Plan:
- Reset: hold nreset_i=0 for 3 cycles while v_i=1, data_i=8'hAA -> v_o=0, data_o=0, ready_o=1. After release, the first enq appears on data_o next cycle.
- Streaming with width_p=8, yumi_i held 1, v_i=1, data 1,2,3,...,20 -> output sequence 1..20 in order at 1/cycle, with ready_o never dropping.
- Back-pressure: enq 8'h11 and 8'h22 with yumi_i=0 -> ready_o=0 after second enq and v_i=1 of 8'h33 is not taken. Raising yumi_i then yields 11, 22, 33 in order.
- Simultaneous enq and deq in ONE state -> state stays ONE, v_o stays 1, and head advances to the new data the next cycle.
- Reset mid-operation in FULL: assert nreset_i=0 for one cycle -> v_o=0, ready_o=1 next cycle, and old data never emerges.
- Stall counter with the macro defined: hold v_o=1, yumi_i=0 for 70000 cycles -> stall_cnt_o=16'hFFFF (saturated). Without the macro, stall_cnt_o=0 throughout.
